// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared CPU bus addresses and OAM DMA state encoding
package nes_bus_pkg;
  localparam logic [15:0] ADDR_SPR_RAM_DMA  = 16'h4014;
  localparam logic [15:0] ADDR_SPR_RAM_DATA = 16'h2004;
  typedef enum logic [2:0] {IDLE, ALIGN, ALIGN_ODD, READ, WRITE} dma_state_t;
endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: CPU bus pass-through that steals the bus for 256-byte sprite DMA
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_SPR_RAM_DMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_SPR_RAM_DATA,
  parameter int          DMA_LEN       = 256
) (
  input  logic        clk,
  input  logic        b_rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy
);
  dma_state_t state, nxt;
  logic [7:0] page, idx, latch;
  logic       par, trig, last, idle;
  assign idle = state == IDLE;
  assign trig = idle && cpu_wen && cpu_addr == DMA_REG_ADDR;
  assign last = idx == 8'(DMA_LEN - 1);
  // state, source pointer, data latch and free-running parity
  always_ff @(posedge clk) begin
    if (!b_rst) begin
      state <= IDLE;
      page  <= '0;
      idx   <= '0;
      latch <= '0;
      par   <= 1'b0;
    end else begin
      state <= nxt;
      par   <= ~par;
      if (trig) begin
        page <= cpu_wdata;
        idx  <= '0;
      end
      if (state == READ) latch <= mem_rdata;
      if (state == WRITE && !last) idx <= idx + 8'd1;
    end
  end
  // next state: an odd-parity ALIGN cycle costs one extra dead cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = trig ? ALIGN : IDLE;
      ALIGN:     nxt = par ? ALIGN_ODD : READ;
      ALIGN_ODD: nxt = READ;
      READ:      nxt = WRITE;
      WRITE:     nxt = last ? IDLE : READ;
      default:   nxt = IDLE;
    endcase
  end
  // bus mux: CPU owns the bus in IDLE, the DMA engine owns it otherwise
  always_comb begin
    cpu_rdy   = idle;
    dma_busy  = !idle;
    cpu_rdata = idle ? mem_rdata : 8'h00;
    mem_addr  = idle ? cpu_addr : state == READ ? {page, idx} : state == WRITE ? OAM_DATA_ADDR : 16'h0000;
    mem_wdata = idle ? cpu_wdata : state == WRITE ? latch : 8'h00;
    mem_ren   = idle ? cpu_ren : state == READ;
    mem_wen   = idle ? cpu_wen : state == WRITE;
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: randomized self-checking bench for the OAM DMA controller
module tb_oam_dma_ctrl;
  logic        clk = 0, b_rst = 0;
  logic [15:0] cpu_addr = 0, mem_addr;
  logic [7:0]  cpu_wdata = 0, cpu_rdata, mem_wdata, mem_rdata;
  logic        cpu_ren = 0, cpu_wen = 0, cpu_rdy, mem_ren, mem_wen, dma_busy;
  logic [7:0]  mem [0:65535];
  int          ncyc = 0, tests = 0, fails = 0;

  oam_dma_ctrl dut (
    .clk(clk), .b_rst(b_rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  // memory map model: writes land at the clock edge
  always @(posedge clk) if (mem_wen === 1'b1) mem[mem_addr] = mem_wdata;
  // cycles since reset: its LSB is the expected cycle parity
  always @(posedge clk) ncyc <= b_rst ? ncyc + 1 : 0;

  task automatic idle_inputs();
    cpu_addr = 0; cpu_wdata = 0; cpu_ren = 0; cpu_wen = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    b_rst = 0;
    repeat (3) @(posedge clk);
    #1 b_rst = 1;
    @(negedge clk);
    tests++; if (cpu_rdy !== 1) begin fails++; $display("FAIL reset_rdy: got %b want 1", cpu_rdy); end
    tests++; if (dma_busy !== 0) begin fails++; $display("FAIL reset_busy: got %b want 0", dma_busy); end
    tests++; if (mem_ren !== 0 || mem_wen !== 0) begin fails++; $display("FAIL reset_strobes: got ren=%b wen=%b want 0 0", mem_ren, mem_wen); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    cpu_addr = 16'h0055; cpu_wdata = 8'hA5; cpu_wen = 1; #1;
    tests++; if (mem_wen !== 1 || mem_addr !== 16'h0055 || mem_wdata !== 8'hA5) begin fails++; $display("FAIL pt_write: got wen=%b addr=%h data=%h want 1 0055 a5", mem_wen, mem_addr, mem_wdata); end
    tests++; if (cpu_rdy !== 1) begin fails++; $display("FAIL pt_write_rdy: got %b want 1", cpu_rdy); end
    @(negedge clk);
    cpu_wen = 0; cpu_ren = 1; #1;
    tests++; if (mem_ren !== 1 || cpu_rdata !== 8'hA5) begin fails++; $display("FAIL pt_read: got ren=%b rdata=%h want 1 a5", mem_ren, cpu_rdata); end
    @(negedge clk);
    cpu_addr = 16'h4014; cpu_ren = 1; #1;
    tests++; if (mem_ren !== 1 || mem_addr !== 16'h4014) begin fails++; $display("FAIL pt_read_dma_reg: got ren=%b addr=%h want 1 4014", mem_ren, mem_addr); end
    @(negedge clk);
    cpu_addr = 16'h0077; cpu_wdata = 8'h5A; cpu_ren = 1; cpu_wen = 1; #1;
    tests++; if (cpu_rdy !== 1) begin fails++; $display("FAIL read_no_trigger: got rdy=%b want 1", cpu_rdy); end
    tests++; if (mem_ren !== 1 || mem_wen !== 1 || mem_addr !== 16'h0077 || mem_wdata !== 8'h5A) begin fails++; $display("FAIL pt_both: got ren=%b wen=%b addr=%h data=%h want 1 1 0077 5a", mem_ren, mem_wen, mem_addr, mem_wdata); end
    @(negedge clk);
    idle_inputs(); #1;
    tests++; if (cpu_rdy !== 1 || mem[16'h0077] !== 8'h5A) begin fails++; $display("FAIL pt_both_after: got rdy=%b mem=%h want 1 5a", cpu_rdy, mem[16'h0077]); end
  endtask

  task automatic run_dma(input logic [7:0] pg, input bit odd, input bit hold, input bit pattern, input int abort_at);
    logic [7:0] exp [256];
    int stall, nr, nw, first_rd, rd_bad, wr_bad, busy_bad, gap_bad;
    bit done, aborted;
    for (int i = 0; i < 256; i++) begin
      exp[i] = pattern ? (8'(i) ^ 8'h3C) : 8'($urandom);
      mem[{pg, 8'(i)}] = exp[i];
    end
    @(negedge clk);
    while (ncyc[0] == odd) @(negedge clk);
    cpu_addr = 16'h4014; cpu_wdata = pg; cpu_ren = 0; cpu_wen = 1; #1;
    tests++; if (mem_wen !== 1 || mem_addr !== 16'h4014 || mem_wdata !== pg || cpu_rdy !== 1) begin fails++; $display("FAIL trigger_fwd: got wen=%b addr=%h data=%h rdy=%b want 1 4014 %h 1", mem_wen, mem_addr, mem_wdata, cpu_rdy, pg); end
    @(posedge clk); #1;
    if (hold) cpu_wdata = 8'h07; else idle_inputs();
    stall = 0; nr = 0; nw = 0; first_rd = -1; rd_bad = 0; wr_bad = 0; busy_bad = 0; gap_bad = 0; done = 0; aborted = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (cpu_rdy === 1) begin
        done = 1;
        idle_inputs();
      end else begin
        stall++;
        if (dma_busy !== 1 || cpu_rdata !== 0) busy_bad++;
        if (mem_ren === 1) begin
          if (first_rd < 0) first_rd = stall - 1;
          if (mem_wen !== 0 || mem_addr !== {pg, 8'(nr)}) rd_bad++;
          nr++;
        end else if (mem_wen === 1) begin
          if (mem_addr !== 16'h2004 || nw > 255 || mem_wdata !== exp[nw[7:0]]) wr_bad++;
          nw++;
          if (nw == abort_at) begin b_rst = 0; aborted = 1; done = 1; end
        end else if (stall > 1 + int'(odd)) gap_bad++;
      end
    end
    if (aborted) begin
      @(posedge clk); #1 b_rst = 1;
      @(negedge clk);
      tests++; if (cpu_rdy !== 1 || dma_busy !== 0) begin fails++; $display("FAIL abort_idle: got rdy=%b busy=%b want 1 0", cpu_rdy, dma_busy); end
      tests++; if (mem_ren !== 0 || mem_wen !== 0) begin fails++; $display("FAIL abort_strobes: got ren=%b wen=%b want 0 0", mem_ren, mem_wen); end
      tests++; if (nr != abort_at || wr_bad != 0 || rd_bad != 0) begin fails++; $display("FAIL abort_prefix: got reads=%0d wr_bad=%0d rd_bad=%0d want %0d 0 0", nr, wr_bad, rd_bad, abort_at); end
      return;
    end
    tests++; if (!done) begin fails++; $display("FAIL dma_timeout: got no cpu_rdy within 600 cycles want done"); end
    tests++; if (stall != 513 + int'(odd)) begin fails++; $display("FAIL dma_stall pg=%h: got %0d want %0d", pg, stall, 513 + int'(odd)); end
    tests++; if (first_rd != 1 + int'(odd)) begin fails++; $display("FAIL dma_first_read: got %0d want %0d", first_rd, 1 + int'(odd)); end
    tests++; if (nr != 256 || nw != 256) begin fails++; $display("FAIL dma_counts: got reads=%0d writes=%0d want 256 256", nr, nw); end
    tests++; if (rd_bad != 0) begin fails++; $display("FAIL dma_read_addr: got %0d bad reads want 0", rd_bad); end
    tests++; if (wr_bad != 0) begin fails++; $display("FAIL dma_write_data: got %0d bad writes want 0", wr_bad); end
    tests++; if (busy_bad != 0 || gap_bad != 0) begin fails++; $display("FAIL dma_busy_gap: got busy_bad=%0d gap_bad=%0d want 0 0", busy_bad, gap_bad); end
    tests++; if (dma_busy !== 0) begin fails++; $display("FAIL dma_done_busy: got %b want 0", dma_busy); end
    @(negedge clk);
    tests++; if (cpu_rdy !== 1 || mem_ren !== 0 || mem_wen !== 0) begin fails++; $display("FAIL dma_after: got rdy=%b ren=%b wen=%b want 1 0 0", cpu_rdy, mem_ren, mem_wen); end
  endtask

  task automatic test_even_dma();  run_dma(8'h02, 0, 0, 1, 0); endtask
  task automatic test_odd_dma();   run_dma(8'h02, 1, 0, 1, 0); endtask
  task automatic test_page_ff();   run_dma(8'hFF, $urandom_range(0, 1) == 1, 0, 0, 0); endtask
  task automatic test_busy_ignore(); run_dma(8'h03, 0, 1, 0, 0); endtask

  task automatic test_reset_mid();
    run_dma(8'h05, 0, 0, 0, 100);
    run_dma(8'h05, 1, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] pg;
    for (int k = 0; k < 3; k++) begin
      do pg = 8'($urandom); while (pg == 8'h20 || pg == 8'h40);
      run_dma(pg, $urandom_range(0, 1) == 1, 0, 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_passthrough();
    test_even_dma();
    test_odd_dma();
    test_page_ff();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
